txs_frame_writer: RTL and testbench

- Downstream of the camera word packers inside top; upstream of the PCIe TX-slave (txs) Avalon-MM write port.
- Accepts a 128-bit frame word stream, buffers it in a FIFO, and issues Avalon-MM write bursts into one of two ping-pong host frame buffers.
- Raises a one-cycle frame-done event per completed frame; the event drives irq.

---
 rtl/txs_frame_writer.sv | 194 +++++++++++++++++++
 tb/tb_txs_frame_writer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/txs_frame_writer.sv
// txs_frame_writer: buffers a 128-bit frame word stream in a show-ahead FIFO
// and writes it as Avalon-MM bursts into one of two ping-pong host frame
// buffers, raising a one-cycle frame_done event when a frame's last beat is
// accepted by the TX-slave port.
module txs_frame_writer #(
    parameter int          BURST_LEN    = 32,
    parameter int          FIFO_AW      = 6,
    parameter logic [22:0] FRAME_STRIDE = 23'h10_0000
) (
    input  logic         c,
    input  logic         rst_n,
    input  logic         en,
    input  logic [22:0]  base_addr,
    input  logic [127:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sof,
    input  logic         in_eof,
    input  logic         txs_waitrequest,
    output logic         txs_write,
    output logic [22:0]  txs_address,
    output logic [5:0]   txs_burstcount,
    output logic [127:0] txs_writedata,
    output logic         frame_done,
    output logic         frame_buf,
    output logic [15:0]  err_cnt
);

    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] BURST_CNT = (FIFO_AW + 1)'(BURST_LEN);
    localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [5:0]       BURST_BC  = 6'(BURST_LEN);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    // FIFO storage: {eof flag, data}
    logic [128:0]       mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               eof_held;

    // Frame bookkeeping
    logic               frame_open;
    logic               buf_idx;
    logic [22:0]        wr_off;

    // Burst engine
    state_t             state;
    logic [5:0]         beats_left;

    // Handshake and control decode
    logic               in_acc;
    logic               sof_acc;
    logic               push;
    logic               pop;
    logic               head_eof;
    logic               last_beat;
    logic               last_eof;
    logic               start_cond;
    logic [5:0]         burst_n;
    logic [22:0]        burst_addr;

    // Input is held off after an eof word so the FIFO never mixes two frames.
    assign in_ready = en & (count != FULL_CNT) & ~eof_held;
    assign in_acc   = in_valid & in_ready;
    assign sof_acc  = in_acc & in_sof;
    // Words outside an open frame are accepted but dropped on the floor.
    assign push     = in_acc & (in_sof | frame_open);

    assign head_eof      = mem[rd_ptr][128];
    assign txs_writedata = mem[rd_ptr][127:0];

    assign pop       = txs_write & ~txs_waitrequest;
    assign last_beat = pop & (beats_left == 6'd1);
    assign last_eof  = last_beat & head_eof;

    // A burst starts on a full burst's worth of words, or to flush a frame tail.
    assign start_cond = (count >= BURST_CNT) | (eof_held & (count != '0));
    assign burst_n    = (count >= BURST_CNT) ? BURST_BC : 6'(count);
    assign burst_addr = {base_addr[22:9], 9'd0}
                      + (buf_idx ? FRAME_STRIDE : 23'd0)
                      + wr_off;

    // FIFO storage write port
    // NOTE: the data array carries no reset; only pointers and count define
    // what is valid, so clearing the storage would just cost reset fanout.
    always_ff @(posedge c) begin
        if (push) begin
            mem[wr_ptr] <= {in_eof, in_data};
        end
    end

    // FIFO pointers, occupancy and the "eof word buffered" flag
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            eof_held <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop && head_eof) begin
                eof_held <= 1'b0;
            end
            if (push && in_eof) begin
                eof_held <= 1'b1;
            end
        end
    end

    // Frame tracking: open/abandon detection, buffer ping-pong, write offset
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            frame_open <= 1'b0;
            buf_idx    <= 1'b0;
            wr_off     <= '0;
            err_cnt    <= '0;
            frame_done <= 1'b0;
            frame_buf  <= 1'b0;
        end else begin
            frame_done <= last_eof;
            if (sof_acc) begin
                frame_open <= 1'b1;
                if (frame_open && (err_cnt != 16'hFFFF)) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end else if (last_eof) begin
                frame_open <= 1'b0;
            end
            if (last_eof) begin
                frame_buf <= buf_idx;
                buf_idx   <= ~buf_idx;
            end
            if (sof_acc || last_eof) begin
                wr_off <= '0;
            end else if (pop) begin
                wr_off <= wr_off + 23'd16;
            end
        end
    end

    // Burst engine: latch address/length on entry, stream beats until done
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            txs_write      <= 1'b0;
            txs_address    <= '0;
            txs_burstcount <= '0;
            beats_left     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_cond) begin
                        state          <= BURST;
                        txs_write      <= 1'b1;
                        txs_address    <= burst_addr;
                        txs_burstcount <= burst_n;
                        beats_left     <= burst_n;
                    end
                end
                BURST: begin
                    if (pop) begin
                        beats_left <= beats_left - 6'd1;
                        if (last_beat) begin
                            state     <= IDLE;
                            txs_write <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    txs_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_txs_frame_writer.sv
// tb_txs_frame_writer: randomized frame traffic against a word-level model of
// how frames are cut into bursts and where those bursts land in host memory.
module tb_txs_frame_writer;

    localparam logic [22:0] STRIDE = 23'h10_0000;
    localparam int          BLEN   = 32;
    localparam int          TMO    = 4000;

    logic         c = 1'b0;
    logic         rst_n;
    logic         en;
    logic [22:0]  base_addr;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_sof;
    logic         in_eof;
    logic         txs_waitrequest = 1'b0;
    logic         txs_write;
    logic [22:0]  txs_address;
    logic [5:0]   txs_burstcount;
    logic [127:0] txs_writedata;
    logic         frame_done;
    logic         frame_buf;
    logic [15:0]  err_cnt;

    txs_frame_writer dut (
        .c               (c),
        .rst_n           (rst_n),
        .en              (en),
        .base_addr       (base_addr),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_sof          (in_sof),
        .in_eof          (in_eof),
        .txs_waitrequest (txs_waitrequest),
        .txs_write       (txs_write),
        .txs_address     (txs_address),
        .txs_burstcount  (txs_burstcount),
        .txs_writedata   (txs_writedata),
        .frame_done      (frame_done),
        .frame_buf       (frame_buf),
        .err_cnt         (err_cnt)
    );

    always #4 c = ~c;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [22:0] addr;
        logic [6:0]  n;
        logic        eof;
        logic        bidx;
    } chunk_t;

    chunk_t       chunks[$];
    logic [127:0] exp_beats[$];
    chunk_t       cur;
    int           pend      = 0;
    int           beat_idx  = 0;
    bit           m_open    = 0;
    bit           m_buf     = 0;
    logic [22:0]  m_off     = '0;
    int           err_exp   = 0;
    bit           eof_pending = 0;
    bit           fd_exp    = 0;
    bit           fd_buf    = 0;
    bit           drop_exp  = 0;
    bit           mon_en    = 0;
    bit           ws_rand   = 0;
    bit           ws_force  = 0;

    task automatic model_reset();
        chunks.delete();
        exp_beats.delete();
        pend = 0; beat_idx = 0; m_open = 0; m_buf = 0; m_off = '0;
        err_exp = 0; eof_pending = 0; fd_exp = 0; drop_exp = 0;
    endtask

    // Slave stall generator
    always @(posedge c) begin
        #1;
        txs_waitrequest = ws_rand ? 1'($urandom_range(0, 1)) : ws_force;
    end

    // Monitor: everything is sampled mid-cycle, ahead of the edge that acts on it
    always @(negedge c) begin
        if (mon_en) begin
            if (fd_exp || frame_done) begin
                check("frame_done", 128'(frame_done), 128'(fd_exp));
                if (fd_exp) check("frame_buf", 128'(frame_buf), 128'(fd_buf));
            end
            fd_exp = 0;
            if (drop_exp) check("write_drop", 128'(txs_write), 128'd0);
            drop_exp = 0;
            if (eof_pending) check("in_ready_stall", 128'(in_ready), 128'd0);

            if (txs_write && !txs_waitrequest) begin
                logic [127:0] exp_d;
                if (beat_idx == 0) begin
                    check("burst_expected", 128'(chunks.size() != 0), 128'd1);
                    if (chunks.size() != 0) cur = chunks.pop_front();
                    else begin cur = '0; cur.n = 7'd1; end
                end
                check("burst_addr", 128'(txs_address), 128'(cur.addr));
                check("burst_count", 128'(txs_burstcount), 128'(cur.n));
                exp_d = (exp_beats.size() != 0) ? exp_beats.pop_front() : 'x;
                check("beat_data", txs_writedata, exp_d);
                beat_idx++;
                if (beat_idx >= int'(cur.n)) begin
                    beat_idx = 0;
                    drop_exp = 1;
                    if (cur.eof) begin
                        fd_exp = 1;
                        fd_buf = cur.bidx;
                        eof_pending = 0;
                    end
                end
            end

            if (in_valid && in_ready && (in_sof || m_open)) begin
                if (in_sof) begin
                    if (m_open) err_exp++;
                    m_open = 1;
                    m_off = '0;
                end
                exp_beats.push_back(in_data);
                pend++;
                if (in_eof) begin
                    m_open = 0;
                    eof_pending = 1;
                end
                // A frame is cut into BLEN-word bursts; only its tail is short.
                if (pend == BLEN || in_eof) begin
                    chunk_t ch;
                    ch.addr = (base_addr & 23'h7F_FE00) + (m_buf ? STRIDE : 23'd0) + m_off;
                    ch.n    = 7'(pend);
                    ch.eof  = in_eof;
                    ch.bidx = m_buf;
                    chunks.push_back(ch);
                    m_off = m_off + 23'(16 * pend);
                    pend = 0;
                    if (in_eof) begin
                        m_buf = ~m_buf;
                        m_off = '0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_word(input logic [127:0] d, input logic s, input logic e);
        int t = 0;
        in_data = d; in_sof = s; in_eof = e; in_valid = 1'b1;
        forever begin
            @(negedge c);
            if (in_ready) break;
            t++;
            if (t >= TMO) begin
                check("in_ready_timeout", 128'(in_ready), 128'd1);
                break;
            end
        end
        @(posedge c); #1;
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    endtask

    task automatic send_seq(input int len, input bit sof_first, input bit eof_last, input int gap_max);
        for (int i = 0; i < len; i++) begin
            send_word({$urandom, $urandom, $urandom, $urandom},
                      sof_first && (i == 0), eof_last && (i == len - 1));
            repeat ($urandom_range(0, gap_max)) @(posedge c);
            #0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while ((exp_beats.size() != 0 || eof_pending) && t < TMO) begin
            @(negedge c);
            t++;
        end
        check({tag, "_drain"}, 128'(t < TMO), 128'd1);
        repeat (3) @(posedge c);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; base_addr = '0;
        in_data = '0; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        repeat (3) @(negedge c);
        check("rst_txs_write", 128'(txs_write), 128'd0);
        check("rst_txs_address", 128'(txs_address), 128'd0);
        check("rst_burstcount", 128'(txs_burstcount), 128'd0);
        check("rst_frame_done", 128'(frame_done), 128'd0);
        check("rst_frame_buf", 128'(frame_buf), 128'd0);
        check("rst_err_cnt", 128'(err_cnt), 128'd0);
        @(posedge c); #1;
        rst_n = 1'b1;
        @(negedge c);
        check("en_low_ready", 128'(in_ready), 128'd0);
        @(posedge c); #1;
        en = 1'b1;
        @(negedge c);
        check("en_high_ready", 128'(in_ready), 128'd1);
        @(posedge c); #1;
        mon_en = 1;

        // Directed ping-pong frames: 64, 64, 40 words, no stalls
        send_seq(64, 1, 1, 0); wait_idle("f64_a");
        send_seq(64, 1, 1, 0); wait_idle("f64_b");
        send_seq(40, 1, 1, 0); wait_idle("f40");

        // Random lengths, bases, gaps and slave stalls
        ws_rand = 1;
        for (int f = 0; f < 6; f++) begin
            base_addr = 23'($urandom);
            send_seq($urandom_range(1, 100), 1, 1, 2);
            wait_idle("rand_frame");
        end

        // Stray words outside a frame, then a frame abandoned by an early sof
        base_addr = '0;
        send_seq(3, 0, 0, 0);
        send_seq(10, 1, 0, 1);
        send_seq(50, 1, 1, 1);
        wait_idle("abandon");
        check("err_cnt", 128'(err_cnt), 128'(err_exp));

        // Single-word frame
        ws_rand = 0; ws_force = 0;
        repeat (2) @(posedge c); #1;
        send_seq(1, 1, 1, 0); wait_idle("one_word");

        // Reset while a burst is stalled
        ws_force = 1;
        repeat (2) @(posedge c); #1;
        send_seq(1, 1, 1, 0);
        begin
            int t = 0;
            while (!txs_write && t < 100) begin @(negedge c); t++; end
            check("stall_burst_seen", 128'(txs_write), 128'd1);
        end
        check("stall_burst_bc", 128'(txs_burstcount), 128'd1);
        if (chunks.size() != 0) check("stall_burst_addr", 128'(txs_address), 128'(chunks[0].addr));
        mon_en = 0;
        #2 rst_n = 1'b0;
        #1 check("rst_mid_write", 128'(txs_write), 128'd0);
        model_reset();
        ws_force = 0;
        @(posedge c); #1;
        rst_n = 1'b1;
        check("post_rst_err", 128'(err_cnt), 128'(err_exp));
        check("post_rst_done", 128'(frame_done), 128'd0);
        mon_en = 1;
        send_seq(5, 1, 1, 0); wait_idle("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
